// File: rtl/jac1_pkg.sv
// Shared types and defaults for the Jac1-8 memory arbiter.
// Read-owner encoding records which requester receives next cycle's read data.
package jac1_pkg;

  localparam int JAC1_DATA_W = 8;
  localparam int JAC1_ADDR_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_DBG   = 2'd3
  } owner_t;

endpackage

// File: rtl/jac1_starve_ctr.sv
// Saturating fetch-starvation counter; clear wins over increment, holds when neither.
// Registered count, at_max is a direct decode of the register (no extra latency).
module jac1_starve_ctr #(
  parameter int MaxWait = 4
) (
  input  logic clk,
  input  logic sys_res_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MaxWait);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!sys_res_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/jac1_mem_arbiter.sv
// Single-port RAM arbiter: fetch vs load/store, combinational grant, read data valid one cycle after grant.
// No queuing: requesters hold until gnt. JAC1_ARB_DBG_EN adds a top-priority debug port.
module jac1_mem_arbiter
  import jac1_pkg::*;
#(
  parameter int DataWidth = JAC1_DATA_W,
  parameter int AddrWidth = JAC1_ADDR_W,
  parameter int MaxWait   = 4
) (
  input  logic                 clk,
  input  logic                 sys_res_n,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [AddrWidth-1:0] ls_addr,
  input  logic [DataWidth-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [DataWidth-1:0] ls_rdata,
`ifdef JAC1_ARB_DBG_EN
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [AddrWidth-1:0] dbg_addr,
  input  logic [DataWidth-1:0] dbg_wdata,
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [DataWidth-1:0] dbg_rdata,
`endif
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  logic   w_if_gnt;
  logic   w_ls_gnt;
  logic   w_dbg_gnt;
  logic   w_at_max;
  owner_t w_owner_nxt;
  owner_t r_rd_owner;

  always_comb begin
    w_if_gnt  = 1'b0;
    w_ls_gnt  = 1'b0;
    w_dbg_gnt = 1'b0;
    if (sys_res_n) begin
`ifdef JAC1_ARB_DBG_EN
      if (dbg_req) w_dbg_gnt = 1'b1;
      else
`endif
      if (w_at_max && if_req) w_if_gnt = 1'b1;
      else if (ls_req)        w_ls_gnt = 1'b1;
      else if (if_req)        w_if_gnt = 1'b1;
    end
  end

  // Debug wins leave the count untouched: neither clear nor increment.
  jac1_starve_ctr #(
    .MaxWait(MaxWait)
  ) u_starve (
    .clk      (clk),
    .sys_res_n(sys_res_n),
    .i_inc    (if_req & ~w_if_gnt & ~w_dbg_gnt),
    .i_clr    (~if_req | w_if_gnt),
    .o_at_max (w_at_max)
  );

  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_owner_nxt = OWN_NONE;
    if (w_if_gnt) begin
      mem_addr    = if_addr;
      w_owner_nxt = OWN_FETCH;
    end else if (w_ls_gnt) begin
      mem_we      = ls_we;
      mem_addr    = ls_addr;
      mem_wdata   = ls_we ? ls_wdata : '0;
      w_owner_nxt = ls_we ? OWN_NONE : OWN_DATA;
    end
`ifdef JAC1_ARB_DBG_EN
    else if (w_dbg_gnt) begin
      mem_we      = dbg_we;
      mem_addr    = dbg_addr;
      mem_wdata   = dbg_we ? dbg_wdata : '0;
      w_owner_nxt = dbg_we ? OWN_NONE : OWN_DBG;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!sys_res_n) r_rd_owner <= OWN_NONE;
    else            r_rd_owner <= w_owner_nxt;
  end

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_gnt;
  assign mem_en = w_if_gnt | w_ls_gnt | w_dbg_gnt;

  // Gated by reset so a read in flight when reset lands never reports valid.
  assign if_rvalid = sys_res_n && (r_rd_owner == OWN_FETCH);
  assign ls_rvalid = sys_res_n && (r_rd_owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

`ifdef JAC1_ARB_DBG_EN
  assign dbg_gnt    = w_dbg_gnt;
  assign dbg_rvalid = sys_res_n && (r_rd_owner == OWN_DBG);
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_jac1_mem_arbiter.sv
// Directed self-checking bench for jac1_mem_arbiter; inputs change at posedge+1, outputs checked at posedge+2.
module tb_jac1_mem_arbiter;

  logic       clk = 1'b0;
  logic       sys_res_n;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_gnt;
  logic       if_rvalid;
  logic [7:0] if_rdata;
  logic       ls_req;
  logic       ls_we;
  logic [7:0] ls_addr;
  logic [7:0] ls_wdata;
  logic       ls_gnt;
  logic       ls_rvalid;
  logic [7:0] ls_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef JAC1_ARB_DBG_EN
  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [7:0] dbg_rdata;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jac1_mem_arbiter #(.DataWidth(8), .AddrWidth(8), .MaxWait(4)) dut (
    .clk(clk), .sys_res_n(sys_res_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
`ifdef JAC1_ARB_DBG_EN
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic idle();
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_rdata = 8'h00;
`ifdef JAC1_ARB_DBG_EN
    dbg_req = 1'b0;
`endif
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      total++;
      if ({if_gnt, ls_gnt, mem_en} !== 3'b000) begin
        bad++; $display("FAIL reset_gnt c=%0d: got if/ls/en=%b want 000", c, {if_gnt, ls_gnt, mem_en});
      end
      total++;
      if ({if_rvalid, ls_rvalid} !== 2'b00) begin
        bad++; $display("FAIL reset_rvalid c=%0d: got %b want 00", c, {if_rvalid, ls_rvalid});
      end
    end
    @(posedge clk); #1;
    sys_res_n = 1'b1;
    #1;
    total++;
    if ({ls_gnt, if_gnt, mem_en} !== 3'b101) begin
      bad++; $display("FAIL reset_release: got ls/if/en=%b want 101", {ls_gnt, if_gnt, mem_en});
    end
  endtask

  task automatic test_fetch();
    logic [7:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if_req    = (k < 3);
      if_addr   = 8'h10 + 8'(k);
      exp_d     = 8'hA0 + 8'(k) - 8'h01;
      mem_rdata = (k > 0) ? exp_d : 8'h00;
      #1;
      if (k < 3) begin
        total++;
        if ({if_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 8'h10 + 8'(k)) begin
          bad++; $display("FAIL fetch_issue k=%0d: got gnt/en/we=%b addr=%h want 110 addr=%h",
                          k, {if_gnt, mem_en, mem_we}, mem_addr, 8'h10 + 8'(k));
        end
      end else begin
        total++;
        if ({if_gnt, mem_en} !== 2'b00 || mem_addr !== 8'h00) begin
          bad++; $display("FAIL fetch_idle: got gnt/en=%b addr=%h want 00 addr=00", {if_gnt, mem_en}, mem_addr);
        end
      end
      if (k > 0) begin
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== exp_d || ls_rvalid !== 1'b0 || ls_rdata !== 8'h00) begin
          bad++; $display("FAIL fetch_rdata k=%0d: got rv=%b d=%h ls_rv=%b ls_d=%h want 1 %h 0 00",
                          k, if_rvalid, if_rdata, ls_rvalid, ls_rdata, exp_d);
        end
      end else begin
        total++;
        if (if_rvalid !== 1'b0) begin
          bad++; $display("FAIL fetch_first_rvalid: got %b want 0", if_rvalid);
        end
      end
    end
    @(posedge clk); #2;
    total++;
    if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL fetch_tail_rvalid: got %b want 0", if_rvalid);
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h40; ls_wdata = 8'h5A;
    #1;
    total++;
    if ({ls_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 8'h40 || mem_wdata !== 8'h5A) begin
      bad++; $display("FAIL store_issue: got gnt/en/we=%b addr=%h wd=%h want 111 40 5a",
                      {ls_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    ls_req = 1'b0; ls_we = 1'b0; mem_rdata = 8'hFF;
    #1;
    total++;
    if (ls_rvalid !== 1'b0 || ls_rdata !== 8'h00 || mem_wdata !== 8'h00) begin
      bad++; $display("FAIL store_no_rvalid: got rv=%b d=%h wd=%h want 0 00 00", ls_rvalid, ls_rdata, mem_wdata);
    end
  endtask

  task automatic test_contention();
    logic exp_if;
    logic prev_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 8'h30;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
      #1;
      exp_if = ((i % 5) == 4);
      total++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if || mem_addr !== (exp_if ? 8'h30 : 8'h31)) begin
        bad++; $display("FAIL contention_gnt i=%0d: got if=%b ls=%b addr=%h want if=%b ls=%b",
                        i, if_gnt, ls_gnt, mem_addr, exp_if, !exp_if);
      end
      if (i > 0) begin
        total++;
        if (if_rvalid !== prev_if || ls_rvalid !== !prev_if) begin
          bad++; $display("FAIL contention_rvalid i=%0d: got if=%b ls=%b want if=%b ls=%b",
                          i, if_rvalid, ls_rvalid, prev_if, !prev_if);
        end
      end
      prev_if = exp_if;
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
    #1;
    total++;
    if (ls_gnt !== 1'b1 || mem_addr !== 8'h20) begin
      bad++; $display("FAIL midrd_gnt: got gnt=%b addr=%h want 1 20", ls_gnt, mem_addr);
    end
    @(posedge clk); #1;
    sys_res_n = 1'b0; ls_req = 1'b0; mem_rdata = 8'h77;
    #1;
    total++;
    if (ls_rvalid !== 1'b0 || ls_rdata !== 8'h00 || mem_en !== 1'b0) begin
      bad++; $display("FAIL midrd_in_reset: got rv=%b d=%h en=%b want 0 00 0", ls_rvalid, ls_rdata, mem_en);
    end
    @(posedge clk); #1;
    sys_res_n = 1'b1;
    #1;
    total++;
    if (ls_rvalid !== 1'b0 || dut.r_rd_owner !== jac1_pkg::OWN_NONE) begin
      bad++; $display("FAIL midrd_after: got rv=%b owner=%0d want 0 0", ls_rvalid, dut.r_rd_owner);
    end
  endtask

`ifdef JAC1_ARB_DBG_EN
  task automatic test_dbg();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 8'h30; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h55;
      #1;
      total++;
      if ({dbg_gnt, if_gnt, ls_gnt} !== 3'b100 || mem_addr !== 8'h55 || dut.u_starve.r_cnt !== 4'd4) begin
        bad++; $display("FAIL dbg_win i=%0d: got dbg/if/ls=%b addr=%h cnt=%0d want 100 55 4",
                        i, {dbg_gnt, if_gnt, ls_gnt}, mem_addr, dut.u_starve.r_cnt);
      end
    end
    @(posedge clk); #1;
    dbg_req = 1'b0;
    #1;
    total++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || dbg_rvalid !== 1'b1) begin
      bad++; $display("FAIL dbg_release: got if=%b ls=%b dbg_rv=%b want 1 0 1", if_gnt, ls_gnt, dbg_rvalid);
    end
  endtask
`endif

  initial begin
    sys_res_n = 1'b0;
    if_req = 1'b1; if_addr = 8'h00;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 8'h00;
    mem_rdata = 8'h00;
`ifdef JAC1_ARB_DBG_EN
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
`endif
    test_reset();
    idle();
    test_fetch();
    idle();
    test_store();
    idle();
    test_contention();
    idle();
    test_reset_mid_read();
`ifdef JAC1_ARB_DBG_EN
    idle();
    test_dbg();
`endif
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
